// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - aluop encodings, access FSM states and size/extension decode for the memory stage
package riscv_pkg;

  localparam logic [7:0] ME_NOP_OP = 8'h00;
  localparam logic [7:0] EX_LB_OP  = 8'h20;
  localparam logic [7:0] EX_LH_OP  = 8'h21;
  localparam logic [7:0] EX_LW_OP  = 8'h22;
  localparam logic [7:0] EX_LD_OP  = 8'h23;
  localparam logic [7:0] EX_LBU_OP = 8'h24;
  localparam logic [7:0] EX_LHU_OP = 8'h25;
  localparam logic [7:0] EX_LWU_OP = 8'h26;
  localparam logic [7:0] EX_SB_OP  = 8'h28;
  localparam logic [7:0] EX_SH_OP  = 8'h29;
  localparam logic [7:0] EX_SW_OP  = 8'h2A;
  localparam logic [7:0] EX_SD_OP  = 8'h2B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_WAIT0,
    ST_ISSUE1,
    ST_WAIT1,
    ST_DONE
  } mau_state_e;

  typedef struct packed {
    logic       mem;
    logic       load;
    logic       sign;
    logic [3:0] size;
  } mem_dec_t;

  // Doubleword ops only decode as memory accesses on a 64-bit datapath.
  function automatic mem_dec_t decode_op(input logic [7:0] op, input logic wide);
    mem_dec_t d;
    d = '0;
    case (op)
      EX_LB_OP:  d = '{mem: 1'b1, load: 1'b1, sign: 1'b1, size: 4'd1};
      EX_LH_OP:  d = '{mem: 1'b1, load: 1'b1, sign: 1'b1, size: 4'd2};
      EX_LW_OP:  d = '{mem: 1'b1, load: 1'b1, sign: 1'b1, size: 4'd4};
      EX_LBU_OP: d = '{mem: 1'b1, load: 1'b1, sign: 1'b0, size: 4'd1};
      EX_LHU_OP: d = '{mem: 1'b1, load: 1'b1, sign: 1'b0, size: 4'd2};
      EX_SB_OP:  d = '{mem: 1'b1, load: 1'b0, sign: 1'b0, size: 4'd1};
      EX_SH_OP:  d = '{mem: 1'b1, load: 1'b0, sign: 1'b0, size: 4'd2};
      EX_SW_OP:  d = '{mem: 1'b1, load: 1'b0, sign: 1'b0, size: 4'd4};
      EX_LWU_OP: if (wide) d = '{mem: 1'b1, load: 1'b1, sign: 1'b0, size: 4'd4};
      EX_LD_OP:  if (wide) d = '{mem: 1'b1, load: 1'b1, sign: 1'b1, size: 4'd8};
      EX_SD_OP:  if (wide) d = '{mem: 1'b1, load: 1'b0, sign: 1'b0, size: 4'd8};
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane rotate/mask and load extract/extend across a two-beat window
module mem_lane_align #(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic [OFF_W-1:0]  off_i,
  input  logic [3:0]        size_i,
  input  logic              sign_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic [DATA_W-1:0] st_beat0_o,
  output logic [DATA_W-1:0] st_beat1_o,
  output logic [NB-1:0]     mask0_o,
  output logic [NB-1:0]     mask1_o,
  input  logic [DATA_W-1:0] ld_beat0_i,
  input  logic [DATA_W-1:0] ld_beat1_i,
  output logic [DATA_W-1:0] ld_result_o
);

  logic [OFF_W+2:0]    shamt;
  logic [2*DATA_W-1:0] st_wide;
  logic [2*DATA_W-1:0] ld_shift;
  logic [2*NB-1:0]     ones;
  logic [2*NB-1:0]     mask_wide;
  logic                sbit;

  // Both beats come from one double-width shift: the upper half is what spills into beat 1.
  always_comb begin
    shamt     = {off_i, 3'b000};
    st_wide   = {{DATA_W{1'b0}}, st_data_i} << shamt;
    ones      = '0;
    for (int i = 0; i < 2 * NB; i++) ones[i] = (i < int'(size_i));
    mask_wide = ones << off_i;
    ld_shift  = {ld_beat1_i, ld_beat0_i} >> shamt;
    sbit      = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == int'(size_i) * 8 - 1) sbit = ld_shift[i];
    end
    ld_result_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ld_result_o[i] = (i < int'(size_i) * 8) ? ld_shift[i] : (sign_i & sbit);
    end
    st_beat0_o = st_wide[DATA_W-1:0];
    st_beat1_o = st_wide[2*DATA_W-1:DATA_W];
    mask0_o    = mask_wide[NB-1:0];
    mask1_o    = mask_wide[2*NB-1:NB];
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - registered load/store bus stage; MEM_MISALIGN_SPLIT_EN enables two-beat crossing accesses
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stall_req_o,
  output logic              misalign_err_o,
  output logic              ram_r_enable_o,
  output logic              ram_w_enable_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_w_data_o,
  output logic [NB-1:0]     ram_mask_o,
  input  logic [DATA_W-1:0] ram_r_data_i,
  input  logic              ram_done_i,
  input  logic              ram_busy_i
);

  localparam logic WIDE = (DATA_W == 64);

  mau_state_e        state_q, state_d;
  mem_dec_t          dec_in, dec_q, dec_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic              split_q, split_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] beat0_q, beat0_d;
  logic [DATA_W-1:0] beat1_q, beat1_d;

  logic [OFF_W-1:0]  off_in;
  logic [4:0]        span;
  logic              crossing;
  logic [ADDR_W-1:0] aligned_addr;
  logic [DATA_W-1:0] st_beat0, st_beat1, ld_result;
  logic [NB-1:0]     mask0, mask1;

  assign dec_in       = decode_op(aluop_i, WIDE);
  assign off_in       = addr_i[OFF_W-1:0];
  assign span         = 5'(off_in) + 5'(dec_in.size);
  assign crossing     = dec_in.mem && (span > 5'(NB));
  assign aligned_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .off_i       (addr_q[OFF_W-1:0]),
    .size_i      (dec_q.size),
    .sign_i      (dec_q.sign),
    .st_data_i   (data_q),
    .st_beat0_o  (st_beat0),
    .st_beat1_o  (st_beat1),
    .mask0_o     (mask0),
    .mask1_o     (mask1),
    .ld_beat0_i  (beat0_q),
    .ld_beat1_i  (beat1_q),
    .ld_result_o (ld_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dec_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      beat0_q <= '0;
      beat1_q <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      split_q <= split_d;
      err_q   <= err_d;
      beat0_q <= beat0_d;
      beat1_q <= beat1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    split_d = split_q;
    err_d   = err_q;
    beat0_d = beat0_q;
    beat1_d = beat1_q;
    case (state_q)
      ST_IDLE: begin
        if (dec_in.mem) begin
          dec_d   = dec_in;
          addr_d  = addr_i;
          data_d  = wdata_i;
          wd_d    = wd_i;
          wreg_d  = wreg_i;
          beat0_d = '0;
          beat1_d = '0;
          err_d   = 1'b0;
`ifdef MEM_MISALIGN_SPLIT_EN
          split_d = crossing;
          state_d = ST_ISSUE0;
`else
          split_d = 1'b0;
          if (crossing) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE0;
          end
`endif
        end
      end
      ST_ISSUE0: if (!ram_busy_i) state_d = ST_WAIT0;
      ST_WAIT0: begin
        if (ram_done_i) begin
          beat0_d = ram_r_data_i;
          state_d = split_q ? ST_ISSUE1 : ST_DONE;
        end
      end
      ST_ISSUE1: if (!ram_busy_i) state_d = ST_WAIT1;
      ST_WAIT1: begin
        if (ram_done_i) begin
          beat1_d = ram_r_data_i;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wd_o           = '0;
    wreg_o         = 1'b0;
    wdata_o        = '0;
    stall_req_o    = 1'b0;
    misalign_err_o = 1'b0;
    ram_r_enable_o = 1'b0;
    ram_w_enable_o = 1'b0;
    ram_addr_o     = '0;
    ram_w_data_o   = '0;
    ram_mask_o     = '0;
    case (state_q)
      ST_IDLE: begin
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stall_req_o = dec_in.mem & ~rst;
      end
      ST_ISSUE0: begin
        stall_req_o = 1'b1;
        if (!ram_busy_i) begin
          ram_r_enable_o = dec_q.mem & dec_q.load;
          ram_w_enable_o = dec_q.mem & ~dec_q.load;
          ram_addr_o     = aligned_addr;
          ram_w_data_o   = dec_q.load ? '0 : st_beat0;
          ram_mask_o     = dec_q.load ? {NB{1'b1}} : mask0;
        end
      end
      ST_ISSUE1: begin
        stall_req_o = 1'b1;
        if (!ram_busy_i) begin
          ram_r_enable_o = dec_q.mem & dec_q.load;
          ram_w_enable_o = dec_q.mem & ~dec_q.load;
          ram_addr_o     = aligned_addr + ADDR_W'(NB);
          ram_w_data_o   = dec_q.load ? '0 : st_beat1;
          ram_mask_o     = dec_q.load ? {NB{1'b1}} : mask1;
        end
      end
      ST_WAIT0, ST_WAIT1: stall_req_o = 1'b1;
      ST_DONE: begin
        wd_o           = wd_q;
        wreg_o         = wreg_q & ~err_q;
        wdata_o        = dec_q.load ? ld_result : data_q;
        misalign_err_o = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised, sequential memory-access stage for the RISC-V pipeline, sitting between the EX/MEM latch and the MEM/WB latch and driving the RAM controller port. It replaces combinational load/store steering with a registered FSM that issues one or two bus beats per access and returns sign/zero-extended load data. It supports 32- or 64-bit datapaths, byte-enable masks and, optionally, misaligned accesses split across two aligned beats. It holds the pipeline with `stall_req_o` until the access completes.

## Interface
- DATA_W, 32, datapath/bus width; legal values are 32 and 64.
- ADDR_W, 32, address width.
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- wd_i  in  5  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  DATA_W  ALU result (non-memory ops) or store data
- aluop_i  in  8  operation code from `riscv_pkg`
- addr_i  in  ADDR_W  effective byte address
- wd_o  out  5  destination to WB
- wreg_o  out  1  write enable to WB
- wdata_o  out  DATA_W  result to WB
- stall_req_o  out  1  pipeline hold request
- misalign_err_o  out  1  one-cycle misalignment fault pulse
- ram_r_enable_o  out  1  read request strobe
- ram_w_enable_o  out  1  write request strobe
- ram_addr_o  out  ADDR_W  word-aligned bus address
- ram_w_data_o  out  DATA_W  lane-rotated store data
- ram_mask_o  out  DATA_W/8  byte enables
- ram_r_data_i  in  DATA_W  read data, valid with ram_done_i
- ram_done_i  in  1  beat complete
- ram_busy_i  in  1  controller cannot accept a request

## Operation
- Non-memory op (`ME_NOP_OP`) in IDLE: wd/wreg/wdata pass through combinationally, stall_req_o=0, no bus activity.
- Ops: LB/LH/LW/LBU/LHU/SB/SH/SW. With DATA_W=64, LWU/LD/SD are also supported; with DATA_W=32 they are treated as NOP.
- Lane offset off = addr_i[log2(DATA_W/8)-1:0]; little-endian lanes; ram_addr_o = addr with offset bits cleared.
- Loads: mask all-ones; result = bytes [off, off+size) extended by op (sign for LB/LH/LW, zero for *U).
- Stores: ram_w_data_o = wdata_i shifted left by off*8; mask = size-bit ones shifted left by off.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE.
- IDLE: memory op present → latch op/addr/data/wd/wreg, go to ISSUE0; stall_req_o=1.
- ISSUEn: if !ram_busy_i, assert the relevant enable for exactly one cycle with addr/data/mask valid, then go to WAITn; otherwise hold.
- WAIT0: on ram_done_i capture ram_r_data_i; go to ISSUE1 if the access is split, else DONE.
- WAIT1: on ram_done_i capture the second beat, go to DONE.
- Split beat 1: aligned+DATA_W/8. Lanes are [0, off+size−DATA_W/8). Load data is assembled as {beat1, beat0} >> off*8.
- DONE: wdata_o = assembled result (stores: latched wdata), stall_req_o=0 for one cycle, then IDLE.

## Timing
- Reset (async): state=IDLE. All outputs are 0 except the pass-through outputs, which follow their inputs. Strobes drop immediately, even mid-transaction. A pending ram_done_i after reset is ignored.
- Aligned access with ram_done_i one cycle after the strobe: op seen in cycle 0, strobe in cycle 1, done in cycle 2, DONE (stall low) in cycle 3. The pipeline advances at the end of cycle 3.
- A split access adds 2 cycles minimum.
- A strobe never coincides with ram_busy_i=1. ram_done_i outside WAITn is ignored.
- ram_done_i and ram_busy_i high together in WAITn: done takes priority.

## Configuration
- MEM_MISALIGN_SPLIT_EN defined: crossing accesses (e.g. LW at off=3 on 32-bit, or LH at off=3) split into two beats as above.
- Undefined: a crossing access issues no bus beat. The FSM goes IDLE→DONE with misalign_err_o=1 and wreg_o=0 for the DONE cycle. Non-crossing accesses are unaffected.

## Structure
- `riscv_pkg`: aluop encodings (EX_L*/EX_S*/ME_NOP_OP), the state enum, and a size/extension decode function.
- One sub-module, `mem_lane_align`: combinational store rotate/mask generation and load extract/extend, shared by both beats.

## Test plan
- Reset mid-WAIT0 with ram_r_enable_o seen → outputs zero immediately; next ram_done_i is ignored; a following NOP passes through.
- LB at 0x1003, ram_r_data_i=0x80FF_0000 → wdata_o=0xFFFF_FF80; LBU at the same address → 0x0000_0080.
- SH at 0x2002, wdata_i=0x1234_ABCD, DATA_W=32 → ram_addr_o=0x2000, ram_w_data_o=0xABCD_0000, ram_mask_o=4'b1100.
- ram_busy_i held high 5 cycles in ISSUE0 → no strobe and stall_req_o=1 throughout; strobe appears in the first non-busy cycle.
- With the macro: LW at 0x3003, beat0=0xAA00_0000, beat1=0x00BB_CCDD → two beats (0x3000, 0x3004), wdata_o=0xBBCC_DDAA. Without the macro → no strobe, misalign_err_o pulse, wreg_o=0.
- DATA_W=64: LD at 0x8 with data 0x8000_0000_0000_0001 → wdata_o equals the data; LWU at 0xC → 0x0000_0000_8000_0000.
